// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive end of a 4-channel TDM link.
// Locks to a frame-sync marker on slot 0. Each accepted word goes into one
// registered per-channel output and raises a one-cycle strobe for that channel.
// Sync loss is flagged.
// Optional feature: define TDM_DEMUX_FLYWHEEL_EN to tolerate up to
// SYNC_LOSS-1 consecutive missing slot-0 syncs before lock is dropped.
// Without it, the first missing sync drops lock.
module tdm_demux4 #(
    parameter int W         = 4,
    parameter int SYNC_LOSS = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           E,
    input  logic [W-1:0]   din,
    input  logic           valid,
    input  logic           sync,
    output logic [4*W-1:0] Y,
    output logic [3:0]     Y_valid,
    output logic           frame_done,
    output logic           locked,
    output logic           sync_err
);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [1:0] slot_r;
    logic [1:0] slot_next_s;
    logic       wr_en_s;
    logic [1:0] wr_ch_s;
    logic       err_s;
    logic       accept_s;

`ifdef TDM_DEMUX_FLYWHEEL_EN
    localparam int MISS_W = $clog2(SYNC_LOSS + 1);
    // Miss count at which one more missing sync drops lock.
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(SYNC_LOSS - 1);
    logic [MISS_W-1:0] miss_r;
    logic [MISS_W-1:0] miss_next_s;
`endif

    assign accept_s = E & valid;

    // Next-state logic: pick the slot to write and track the sync state.
    always_comb begin
        state_next_s = state_r;
        slot_next_s  = slot_r;
        wr_en_s      = 1'b0;
        wr_ch_s      = 2'd0;
        err_s        = 1'b0;
`ifdef TDM_DEMUX_FLYWHEEL_EN
        miss_next_s  = miss_r;
`endif
        if (accept_s) begin
            case (state_r)
                HUNT: begin
                    if (sync) begin
                        wr_en_s      = 1'b1;
                        wr_ch_s      = 2'd0;
                        slot_next_s  = 2'd1;
                        state_next_s = LOCKED;
`ifdef TDM_DEMUX_FLYWHEEL_EN
                        miss_next_s  = '0;
`endif
                    end else begin
                        // The word is not part of a frame we know about. Drop it.
                        slot_next_s  = 2'd0;
                    end
                end
                LOCKED: begin
                    if (slot_r == 2'd0) begin
                        if (sync) begin
                            wr_en_s     = 1'b1;
                            wr_ch_s     = 2'd0;
                            slot_next_s = 2'd1;
`ifdef TDM_DEMUX_FLYWHEEL_EN
                            miss_next_s = '0;
`endif
                        end else begin
                            err_s = 1'b1;
`ifdef TDM_DEMUX_FLYWHEEL_EN
                            if (miss_r == MISS_LAST) begin
                                state_next_s = HUNT;
                                slot_next_s  = 2'd0;
                                miss_next_s  = '0;
                            end else begin
                                // The flywheel assumes the frame is still aligned.
                                wr_en_s     = 1'b1;
                                wr_ch_s     = 2'd0;
                                slot_next_s = 2'd1;
                                miss_next_s = miss_r + MISS_W'(1);
                            end
`else
                            state_next_s = HUNT;
                            slot_next_s  = 2'd0;
`endif
                        end
                    end else begin
                        if (sync) begin
                            // A sync in the middle of a frame: realign to it.
                            err_s       = 1'b1;
                            wr_en_s     = 1'b1;
                            wr_ch_s     = 2'd0;
                            slot_next_s = 2'd1;
`ifdef TDM_DEMUX_FLYWHEEL_EN
                            miss_next_s = '0;
`endif
                        end else begin
                            wr_en_s     = 1'b1;
                            wr_ch_s     = slot_r;
                            slot_next_s = slot_r + 2'd1;
                        end
                    end
                end
                default: begin
                    state_next_s = HUNT;
                    slot_next_s  = 2'd0;
                end
            endcase
        end else begin
            // With no word accepted, every piece of state holds.
            state_next_s = state_r;
        end
    end

    // Sync-tracking state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= HUNT;
            slot_r  <= 2'd0;
        end else begin
            state_r <= state_next_s;
            slot_r  <= slot_next_s;
        end
    end

`ifdef TDM_DEMUX_FLYWHEEL_EN
    // Register for the count of consecutive missing syncs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_r <= '0;
        end else begin
            miss_r <= miss_next_s;
        end
    end
`endif

    // Registered outputs: channel data, strobes and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y          <= '0;
            Y_valid    <= 4'b0000;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_en_s && (wr_ch_s == 2'(i))) begin
                    Y[i*W +: W] <= din;
                end
            end
            Y_valid    <= wr_en_s ? (4'b0001 << wr_ch_s) : 4'b0000;
            frame_done <= wr_en_s && (wr_ch_s == 2'd3);
            locked     <= (state_next_s == LOCKED);
            sync_err   <= err_s;
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed testbench for tdm_demux4 (W = 4, SYNC_LOSS = 2).
// The expected values follow whether TDM_DEMUX_FLYWHEEL_EN is defined.
module tb_tdm_demux4;

    logic        clk;
    logic        rst;
    logic        E;
    logic [3:0]  din;
    logic        valid;
    logic        sync;
    logic [15:0] Y;
    logic [3:0]  Y_valid;
    logic        frame_done;
    logic        locked;
    logic        sync_err;

    int tests_run;
    int tests_failed;

    tdm_demux4 #(.W(4), .SYNC_LOSS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .E          (E),
        .din        (din),
        .valid      (valid),
        .sync       (sync),
        .Y          (Y),
        .Y_valid    (Y_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] y, input logic [3:0] yv,
                             input logic fd, input logic lk, input logic se);
        check({tag, ".Y"},          Y,                   y);
        check({tag, ".Y_valid"},    {12'd0, Y_valid},    {12'd0, yv});
        check({tag, ".frame_done"}, {15'd0, frame_done}, {15'd0, fd});
        check({tag, ".locked"},     {15'd0, locked},     {15'd0, lk});
        check({tag, ".sync_err"},   {15'd0, sync_err},   {15'd0, se});
    endtask

    // One accepted-word cycle. On return, the outputs show the result of that word.
    task automatic step(input logic [3:0] d, input logic s);
        din   = d;
        sync  = s;
        valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Assert rst partway through a cycle, check the outputs clear at once, then release it.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check_all(tag, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        valid = 1'b0;
        sync  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        E     = 1'b0;
        din   = 4'h0;
        valid = 1'b0;
        sync  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        E   = 1'b1;

        // Lock onto a frame of 1,2,3,4.
        step(4'h1, 1'b1); check_all("lock_w1", 16'h0001, 4'b0001, 1'b0, 1'b1, 1'b0);
        step(4'h2, 1'b0); check_all("lock_w2", 16'h0021, 4'b0010, 1'b0, 1'b1, 1'b0);
        step(4'h3, 1'b0); check_all("lock_w3", 16'h0321, 4'b0100, 1'b0, 1'b1, 1'b0);
        step(4'h4, 1'b0); check_all("lock_w4", 16'h4321, 4'b1000, 1'b1, 1'b1, 1'b0);
        valid = 1'b0;
        @(posedge clk); #1;
        check_all("idle", 16'h4321, 4'b0000, 1'b0, 1'b1, 1'b0);

        // Hunt: words without sync are dropped.
        async_reset("rst_a");
        step(4'h9, 1'b0); check_all("hunt_w9", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'h8, 1'b0); check_all("hunt_w8", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'h5, 1'b1); check_all("hunt_w5", 16'h0005, 4'b0001, 1'b0, 1'b1, 1'b0);
        step(4'h6, 1'b0); check_all("hunt_w6", 16'h0065, 4'b0010, 1'b0, 1'b1, 1'b0);
        step(4'h7, 1'b0); check_all("hunt_w7", 16'h0765, 4'b0100, 1'b0, 1'b1, 1'b0);
        step(4'h8, 1'b0); check_all("hunt_w8b", 16'h8765, 4'b1000, 1'b1, 1'b1, 1'b0);

        // A slot-0 word arrives without sync.
`ifdef TDM_DEMUX_FLYWHEEL_EN
        step(4'hA, 1'b0); check_all("fly_wA", 16'h876A, 4'b0001, 1'b0, 1'b1, 1'b1);
        step(4'hB, 1'b0); check_all("fly_wB", 16'h87BA, 4'b0010, 1'b0, 1'b1, 1'b0);
        step(4'hC, 1'b0); check_all("fly_wC", 16'h8CBA, 4'b0100, 1'b0, 1'b1, 1'b0);
        step(4'hD, 1'b0); check_all("fly_wD", 16'hDCBA, 4'b1000, 1'b1, 1'b1, 1'b0);
        step(4'h1, 1'b1); check_all("fly_s3", 16'hDCB1, 4'b0001, 1'b0, 1'b1, 1'b0);
`else
        step(4'hA, 1'b0); check_all("miss_wA", 16'h8765, 4'b0000, 1'b0, 1'b0, 1'b1);
`endif

        // Loss of sync starting from a fresh lock.
        async_reset("rst_b");
        step(4'h1, 1'b1);
        step(4'h2, 1'b0);
        step(4'h3, 1'b0);
        step(4'h4, 1'b0); check_all("relock", 16'h4321, 4'b1000, 1'b1, 1'b1, 1'b0);
`ifdef TDM_DEMUX_FLYWHEEL_EN
        // The first miss is written and lock holds; the second miss drops lock.
        step(4'hE, 1'b0); check_all("loss_m1", 16'h432E, 4'b0001, 1'b0, 1'b1, 1'b1);
        step(4'h5, 1'b0);
        step(4'h6, 1'b0);
        step(4'h7, 1'b0); check_all("loss_f2", 16'h765E, 4'b1000, 1'b1, 1'b1, 1'b0);
        step(4'hF, 1'b0); check_all("loss_m2", 16'h765E, 4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'h3, 1'b0); check_all("loss_hunt", 16'h765E, 4'b0000, 1'b0, 1'b0, 1'b0);
`else
        step(4'hF, 1'b0); check_all("loss_m1", 16'h4321, 4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'h3, 1'b0); check_all("loss_hunt", 16'h4321, 4'b0000, 1'b0, 1'b0, 1'b0);
`endif

        // Realign on a sync that arrives in slot 2.
        async_reset("rst_c");
        step(4'h1, 1'b1);
        step(4'h2, 1'b0); check_all("ra_pre", 16'h0021, 4'b0010, 1'b0, 1'b1, 1'b0);
        step(4'h7, 1'b1); check_all("ra_sync", 16'h0027, 4'b0001, 1'b0, 1'b1, 1'b1);
        step(4'h9, 1'b0); check_all("ra_next", 16'h0097, 4'b0010, 1'b0, 1'b1, 1'b0);

        // While E is low, nothing moves, even with valid words present.
        E = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(4'hC, (k == 1) ? 1'b1 : 1'b0);
            check_all("en_low", 16'h0097, 4'b0000, 1'b0, 1'b1, 1'b0);
        end
        E = 1'b1;
        step(4'h3, 1'b0); check_all("en_resume", 16'h0397, 4'b0100, 1'b0, 1'b1, 1'b0);
        step(4'h4, 1'b0); check_all("en_w4", 16'h4397, 4'b1000, 1'b1, 1'b1, 1'b0);

        // Reset mid-frame, then the first word after reset needs sync.
        step(4'h5, 1'b1); check_all("pre_rst", 16'h4395, 4'b0001, 1'b0, 1'b1, 1'b0);
        async_reset("rst_mid");
        step(4'h6, 1'b0); check_all("post_nosync", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'h6, 1'b1); check_all("post_sync", 16'h0006, 4'b0001, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
